// File: rtl/lab9_soc_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : lab9_soc_sysid_checker
// Purpose  : Avalon-MM read master for the 2-word sysid slave. Reads word 0
//            (system ID) and word 1 (build timestamp), captures both and
//            compares them against the expected values, driving
//            done/match/error boot-status flags.
// Ports    : clock, reset_n (async active-low)   - clocking / reset
//            start                               - begin a check (IDLE/DONE only)
//            avm_address, avm_read               - registered read request
//            avm_waitrequest, avm_readdata       - slave response
//            id_value, ts_value                  - captured words
//            busy, done, match, error            - status flags
// Revision : 1.0 - initial release
// ============================================================================
module lab9_soc_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1522111782,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_ID = 3'd1,
        ST_LAT_ID = 3'd2,
        ST_REQ_TS = 3'd3,
        ST_LAT_TS = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Latency counter counts down to zero; zero marks the capture cycle.
    localparam logic [1:0]  LAT_LOAD     = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic        auto_pend, auto_pend_n;
    logic [15:0] stall_cnt, stall_cnt_n;
    logic [1:0]  lat_cnt, lat_cnt_n;
    logic [31:0] id_value_n, ts_value_n;
    logic        done_n, match_n, error_n;
    logic        read_n, address_n, busy_n;
    logic        accept, capture, is_ts;

    always_comb begin
        state_n     = state;
        auto_pend_n = auto_pend;
        stall_cnt_n = stall_cnt;
        lat_cnt_n   = lat_cnt;
        id_value_n  = id_value;
        ts_value_n  = ts_value;
        done_n      = done;
        match_n     = match;
        error_n     = error;
        capture     = 1'b0;
        accept      = avm_read & ~avm_waitrequest;
        is_ts       = (state == ST_REQ_TS) || (state == ST_LAT_TS);

        case (state)
            ST_IDLE: begin
                // auto_pend is set only by reset, so auto-start fires once per release
                if (auto_pend || start) begin
                    state_n     = ST_REQ_ID;
                    auto_pend_n = 1'b0;
                    stall_cnt_n = 16'd0;
                end
            end
            ST_REQ_ID, ST_REQ_TS: begin
                if (accept) begin
                    if (READ_LATENCY == 0) begin
                        capture = 1'b1;
                    end else begin
                        state_n   = is_ts ? ST_LAT_TS : ST_LAT_ID;
                        lat_cnt_n = LAT_LOAD;
                    end
                end else if (avm_waitrequest) begin
                    if (stall_cnt == TIMEOUT_LAST) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                        error_n = 1'b1;
                        match_n = 1'b0;
                    end else begin
                        stall_cnt_n = stall_cnt + 16'd1;
                    end
                end
            end
            ST_LAT_ID, ST_LAT_TS: begin
                if (lat_cnt == 2'd0) begin
                    capture = 1'b1;
                end else begin
                    lat_cnt_n = lat_cnt - 2'd1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_n     = ST_REQ_ID;
                    stall_cnt_n = 16'd0;
                    done_n      = 1'b0;
                    match_n     = 1'b0;
                    error_n     = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (capture) begin
            if (is_ts) begin
                ts_value_n = avm_readdata;
                state_n    = ST_DONE;
                done_n     = 1'b1;
                match_n    = (id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
            end else begin
                id_value_n  = avm_readdata;
                state_n     = ST_REQ_TS;
                stall_cnt_n = 16'd0;
            end
        end

        // Bus outputs are derived from the next state and registered below.
        read_n    = (state_n == ST_REQ_ID) || (state_n == ST_REQ_TS);
        address_n = (state_n == ST_REQ_TS) || (state_n == ST_LAT_TS);
        busy_n    = (state_n != ST_IDLE) && (state_n != ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            auto_pend   <= AUTO_START;
            stall_cnt   <= 16'd0;
            lat_cnt     <= 2'd0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            done        <= 1'b0;
            match       <= 1'b0;
            error       <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            auto_pend   <= auto_pend_n;
            stall_cnt   <= stall_cnt_n;
            lat_cnt     <= lat_cnt_n;
            id_value    <= id_value_n;
            ts_value    <= ts_value_n;
            done        <= done_n;
            match       <= match_n;
            error       <= error_n;
            avm_read    <= read_n;
            avm_address <= address_n;
            busy        <= busy_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lab9_soc_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab9_soc_sysid_checker
// Purpose  : Self-checking bench. Instance 0 uses default parameters with a
//            configurable wait-state slave; instance 1 uses READ_LATENCY=2 and
//            TIMEOUT_CYCLES=8 with a pipelined slave and a stuck-wait option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab9_soc_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1522111782;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- instance 0: zero-latency, configurable wait states
    logic        rst0_n, start0, addr0, read0, wait0;
    logic [31:0] rdata0, id0, ts0;
    logic        busy0, done0, match0, err0;
    logic [31:0] s0_id, s0_ts;
    int          s0_wait = 0;
    int          s0_wcnt = 0;
    int          acc0_id = 0, acc0_ts = 0, hold_err0 = 0;
    logic        prev_stall0 = 1'b0, prev_addr0 = 1'b0;

    assign wait0  = read0 && (s0_wcnt < s0_wait);
    assign rdata0 = addr0 ? s0_ts : s0_id;

    always @(posedge clk) begin
        if (read0 && wait0) s0_wcnt <= s0_wcnt + 1;
        else                s0_wcnt <= 0;
        if (read0 && !wait0) begin
            if (addr0) acc0_ts <= acc0_ts + 1;
            else       acc0_id <= acc0_id + 1;
        end
        prev_stall0 <= read0 && wait0;
        prev_addr0  <= addr0;
    end

    // A stalled request must still be present, unchanged, in the next cycle.
    always @(negedge clk)
        if (prev_stall0 && !(read0 && (addr0 == prev_addr0))) hold_err0 <= hold_err0 + 1;

    lab9_soc_sysid_checker dut0 (
        .clock(clk), .reset_n(rst0_n), .start(start0),
        .avm_address(addr0), .avm_read(read0), .avm_waitrequest(wait0),
        .avm_readdata(rdata0), .id_value(id0), .ts_value(ts0),
        .busy(busy0), .done(done0), .match(match0), .error(err0)
    );

    // ---------------- instance 1: 2-cycle read latency, timeout 8
    logic        rst1_n, start1, addr1, read1, wait1;
    logic [31:0] rdata1, id1, ts1;
    logic        busy1, done1, match1, err1;
    logic        stuck1;
    int          pc1 = 0;
    logic        pa1 = 1'b0;
    int          acc1_id = 0, acc1_ts = 0;

    assign wait1  = stuck1;
    // Data is only valid exactly two cycles after the accept; garbage otherwise.
    assign rdata1 = (pc1 == 1) ? (pa1 ? TS_GOOD : 32'd0) : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (read1 && !wait1) begin
            pa1 <= addr1;
            pc1 <= 2;
            if (addr1) acc1_ts <= acc1_ts + 1;
            else       acc1_id <= acc1_id + 1;
        end else if (pc1 != 0) begin
            pc1 <= pc1 - 1;
        end
    end

    lab9_soc_sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(8)) dut1 (
        .clock(clk), .reset_n(rst1_n), .start(start1),
        .avm_address(addr1), .avm_read(read1), .avm_waitrequest(wait1),
        .avm_readdata(rdata1), .id_value(id1), .ts_value(ts1),
        .busy(busy1), .done(done1), .match(match1), .error(err1)
    );

    typedef struct {
        logic [31:0] id_word;
        logic [31:0] ts_word;
        int          waits;
        logic        exp_match;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int a_id, a_ts, h, cyc, stalls;
        logic found;

        rst0_n = 1'b0; rst1_n = 1'b0; start0 = 1'b0; start1 = 1'b0; stuck1 = 1'b1;
        s0_id = 32'd0; s0_ts = TS_GOOD;

        vecs[0] = '{32'd0, TS_GOOD,                 0, 1'b1, 3};
        vecs[1] = '{32'd0, 32'd1522111783,          0, 1'b0, 3};
        vecs[2] = '{32'd0, TS_GOOD,                 3, 1'b1, 9};
        vecs[3] = '{32'd1, TS_GOOD,                 1, 1'b0, 5};
        vecs[4] = '{32'd0, TS_GOOD ^ 32'h8000_0000, 0, 1'b0, 3};

        // ---------------- table-driven runs on instance 0 (auto-start)
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rst0_n  = 1'b0;
            s0_id   = vecs[i].id_word;
            s0_ts   = vecs[i].ts_word;
            s0_wait = vecs[i].waits;
            @(negedge clk);
            chk($sformatf("v%0d reset flags", i), {26'd0, read0, addr0, busy0, done0, match0, err0}, 32'd0);
            chk($sformatf("v%0d reset values", i), id0 | ts0, 32'd0);
            a_id = acc0_id; a_ts = acc0_ts; h = hold_err0;
            rst0_n = 1'b1;
            cyc = 0;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk); @(negedge clk);
                if (done0) begin cyc = c; break; end
            end
            chk($sformatf("v%0d cycles to done", i), cyc, vecs[i].exp_cycles);
            chk($sformatf("v%0d match", i), {31'd0, match0}, {31'd0, vecs[i].exp_match});
            chk($sformatf("v%0d error/busy", i), {30'd0, err0, busy0}, 32'd0);
            chk($sformatf("v%0d id_value", i), id0, vecs[i].id_word);
            chk($sformatf("v%0d ts_value", i), ts0, vecs[i].ts_word);
            chk($sformatf("v%0d id accepts", i), acc0_id - a_id, 1);
            chk($sformatf("v%0d ts accepts", i), acc0_ts - a_ts, 1);
            chk($sformatf("v%0d hold violations", i), hold_err0 - h, 0);
            repeat (4) @(negedge clk);
            chk($sformatf("v%0d quiet in done", i), {29'd0, read0, busy0, done0}, 32'd1);
            chk($sformatf("v%0d no extra reads", i), (acc0_id - a_id) + (acc0_ts - a_ts), 2);
        end

        // ---------------- start from DONE clears flags, holds values, reruns
        s0_id = 32'd0; s0_ts = TS_GOOD; s0_wait = 0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("restart clears flags", {29'd0, done0, match0, busy0}, 32'd1);
        chk("restart holds ts", ts0, TS_GOOD ^ 32'h8000_0000);
        cyc = 0;
        for (int c = 2; c <= 20; c++) begin
            @(posedge clk); @(negedge clk);
            if (done0) begin cyc = c; break; end
        end
        chk("restart cycles", cyc, 3);
        chk("restart match", {31'd0, match0}, 32'd1);

        // ---------------- instance 1: auto-start into a stuck slave -> timeout
        chk("i1 reset flags", {26'd0, read1, addr1, busy1, done1, match1, err1}, 32'd0);
        rst1_n = 1'b1;
        stalls = 0; found = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); @(negedge clk);
            if (read1 && wait1) stalls++;
            if (done1) begin found = 1'b1; break; end
        end
        chk("timeout reached", {31'd0, found}, 32'd1);
        chk("timeout stall cycles", stalls, 8);
        chk("timeout flags", {27'd0, read1, busy1, done1, match1, err1}, 32'b00101);
        chk("timeout values held", id1 | ts1, 32'd0);
        chk("timeout accepts", acc1_id + acc1_ts, 0);
        repeat (3) @(negedge clk);
        chk("no auto refire", {30'd0, busy1, read1}, 32'd0);

        // ---------------- latency-2 capture, start while busy ignored
        stuck1 = 1'b0;
        a_id = acc1_id; a_ts = acc1_ts;
        cyc = 0;
        for (int c = 1; c <= 30; c++) begin
            start1 = (c == 1) || (c == 3);
            @(posedge clk);
            @(negedge clk);
            if (c == 1) chk("lat restart clears", {29'd0, err1, done1, busy1}, 32'd1);
            if (done1) begin cyc = c; break; end
        end
        start1 = 1'b0;
        chk("lat cycles", cyc, 7);
        chk("lat match", {30'd0, match1, err1}, 32'b10);
        chk("lat id_value", id1, 32'd0);
        chk("lat ts_value", ts1, TS_GOOD);
        chk("lat accepts", (acc1_id - a_id) * 16 + (acc1_ts - a_ts), 17);

        // ---------------- reset asserted during LAT_TS, auto-start reruns
        a_ts = acc1_ts;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (busy1 && !read1 && (acc1_ts != a_ts)) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("reached LAT_TS", {31'd0, found}, 32'd1);
        #2 rst1_n = 1'b0;
        #1;
        chk("async reset flags", {26'd0, read1, addr1, busy1, done1, match1, err1}, 32'd0);
        chk("async reset values", id1 | ts1, 32'd0);
        @(negedge clk);
        rst1_n = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); @(negedge clk);
            if (done1) begin cyc = c; break; end
        end
        chk("rerun cycles", cyc, 7);
        chk("rerun match", {30'd0, match1, err1}, 32'b10);
        chk("rerun ts_value", ts1, TS_GOOD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
